avm_copy_dma: RTL and testbench

Avalon-MM bus initiator that moves blocks of 32-bit words between two addresses on the system bus with no CPU involvement. It is programmed through a small register slave at one 64 KiB decode window of the system interconnect. Its own master port enters the interconnect beside the CPU master, so it can reach SDRAM, on-chip SRAM and peripherals. Completion is reported by a status bit and an optional interrupt line.

---
 rtl/avm_copy_dma.sv | 172 +++++++++++++++++
 tb/tb_avm_copy_dma.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avm_copy_dma.sv
// avm_copy_dma: Avalon-MM block copy engine.
//
// Moves LEN 32-bit words from SRC to DST over its own bus initiator port,
// one read followed by one write per word. It is programmed through a
// four-register slave.
//
// Optional feature: define DMA_FILL_EN to add fill mode (CTRL bit3). In fill
// mode the SRC value is written LEN times and no reads are issued.
//
// Ports
//   clk, reset          : system clock, asynchronous active-high reset
//   avs_s0_*            : register slave
//                         0 = SRC, 1 = DST, 2 = LEN, 3 = CTRL/STATUS
//   avm_m0_*            : bus initiator (word-aligned, full byte enables)
//   irq                 : done & irq_en
//
// State table
//   IDLE | no bus request, registers writable
//   RD   | read request at src, waiting for accept
//   WR   | write request at dst, waiting for accept

module avm_copy_dma (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_s0_address,
    input  logic        avs_s0_read,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_writedata,
    input  logic [3:0]  avs_s0_byteenable,
    output logic [31:0] avs_s0_readdata,
    output logic        avs_s0_waitrequest,
    output logic [31:0] avm_m0_address,
    output logic        avm_m0_read,
    output logic        avm_m0_write,
    output logic [31:0] avm_m0_writedata,
    output logic [3:0]  avm_m0_byteenable,
    input  logic [31:0] avm_m0_readdata,
    input  logic        avm_m0_waitrequest,
    output logic        irq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    logic [1:0]  state;
    logic [31:0] src;
    logic [31:0] dst;
    logic [23:0] len;
    logic [31:0] data_q;
    logic        done;
    logic        irq_en;
    logic        fill;
    logic        fill_next;
    logic        busy;
    logic        ctrl_wr;

    // Slave read strobe and byte enables carry no information for this block.
    logic unused_inputs;
    assign unused_inputs = ^{avs_s0_read, avs_s0_byteenable};

    assign busy    = (state != ST_IDLE);
    assign ctrl_wr = avs_s0_write && (avs_s0_address == 2'd3);

`ifdef DMA_FILL_EN
    logic fill_q;

    // The mode bit written together with start selects the mode of that run.
    assign fill_next = avs_s0_writedata[3];
    assign fill      = fill_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q <= 1'b0;
        end else if (ctrl_wr && !busy) begin
            fill_q <= avs_s0_writedata[3];
        end
    end
`else
    assign fill_next = 1'b0;
    assign fill      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            src    <= 32'd0;
            dst    <= 32'd0;
            len    <= 24'd0;
            data_q <= 32'd0;
            done   <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= avs_s0_writedata[2];
                if (avs_s0_writedata[1]) begin
                    done <= 1'b0;
                end
            end

            // Assignments below follow the clear-done above, so a completion or
            // a start in the same cycle overrides the clear.
            case (state)
                ST_IDLE: begin
                    if (avs_s0_write) begin
                        case (avs_s0_address)
                            2'd0:    src <= {avs_s0_writedata[31:2], 2'b00};
                            2'd1:    dst <= {avs_s0_writedata[31:2], 2'b00};
                            2'd2:    len <= avs_s0_writedata[23:0];
                            default: ;
                        endcase
                    end
                    if (ctrl_wr && avs_s0_writedata[0]) begin
                        if (len == 24'd0) begin
                            done <= 1'b1;
                        end else begin
                            done  <= 1'b0;
                            state <= fill_next ? ST_WR : ST_RD;
                        end
                    end
                end

                ST_RD: begin
                    if (!avm_m0_waitrequest) begin
                        data_q <= avm_m0_readdata;
                        state  <= ST_WR;
                    end
                end

                ST_WR: begin
                    if (!avm_m0_waitrequest) begin
                        dst <= dst + 32'd4;
                        if (!fill) begin
                            src <= src + 32'd4;
                        end
                        len <= len - 24'd1;
                        if (len == 24'd1) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= fill ? ST_WR : ST_RD;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus outputs are decoded from registered state only. They hold still under
    // waitrequest and drop at once when reset is asserted.
    assign avm_m0_read       = (state == ST_RD);
    assign avm_m0_write      = (state == ST_WR);
    assign avm_m0_address    = (state == ST_WR) ? dst : src;
    assign avm_m0_writedata  = fill ? src : data_q;
    assign avm_m0_byteenable = 4'hF;

    assign avs_s0_waitrequest = 1'b0;
    assign irq                = done & irq_en;

    always_comb begin
        avs_s0_readdata = 32'd0;
        case (avs_s0_address)
            2'd0:    avs_s0_readdata = src;
            2'd1:    avs_s0_readdata = dst;
            2'd2:    avs_s0_readdata = {8'd0, len};
            default: avs_s0_readdata = {28'd0, fill, irq_en, done, busy};
        endcase
    end

endmodule

// File: tb/tb_avm_copy_dma.sv
// Bench for avm_copy_dma: register programming, random-stall bus slave with
// backing memory, and a word-by-word copy model that predicts the bus traffic.

module tb_avm_copy_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  s_addr;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_wd;
    logic [3:0]  s_be;
    logic [31:0] s_rdata;
    logic        s_wait;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_wd;
    logic [3:0]  m_be;
    logic [31:0] m_rdata;
    logic        m_wait;
    logic        irq;

    always #5 clk = ~clk;

    avm_copy_dma dut (
        .clk                (clk),
        .reset              (reset),
        .avs_s0_address     (s_addr),
        .avs_s0_read        (s_read),
        .avs_s0_write       (s_write),
        .avs_s0_writedata   (s_wd),
        .avs_s0_byteenable  (s_be),
        .avs_s0_readdata    (s_rdata),
        .avs_s0_waitrequest (s_wait),
        .avm_m0_address     (m_address),
        .avm_m0_read        (m_read),
        .avm_m0_write       (m_write),
        .avm_m0_writedata   (m_wd),
        .avm_m0_byteenable  (m_be),
        .avm_m0_readdata    (m_rdata),
        .avm_m0_waitrequest (m_wait),
        .irq                (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit        wr;
        bit [31:0] addr;
        bit [31:0] data;
    } xfer_t;

    xfer_t     log_q[$];
    xfer_t     exp_q[$];
    bit [31:0] mem[bit [31:0]];
    bit [31:0] ref_mem[bit [31:0]];

    function automatic bit [31:0] dflt(input bit [31:0] a);
        return a * 32'h9E3779B1 + 32'h01357BDF;
    endfunction

    function automatic bit [31:0] mem_rd(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    // Bus slave: 0 = zero wait, 1 = random 0..3 stalls, 2 = fixed_stall stalls.
    int          stall_mode  = 0;
    int          fixed_stall = 3;
    bit          stab_en     = 1'b1;
    bit          in_req      = 1'b0;
    int          cur_stall   = 0;
    int          st_cnt      = 0;
    logic        p_wait      = 1'b0;
    logic        p_req       = 1'b0;
    logic        p_rd        = 1'b0;
    logic        p_wr        = 1'b0;
    logic [31:0] p_addr      = 32'd0;
    logic [31:0] p_wd        = 32'd0;

    always @(negedge clk) begin
        if (reset) begin
            in_req = 1'b0;
            m_wait = 1'b0;
            p_wait = 1'b0;
            p_req  = 1'b0;
        end else begin
            if (stab_en && p_wait && p_req) begin
                check("stall_addr", m_address, p_addr);
                check("stall_strobes", {30'd0, m_read, m_write}, {30'd0, p_rd, p_wr});
                check("stall_wdata", m_wd, p_wd);
            end
            check("rd_wr_excl", 32'(m_read & m_write), 32'd0);
            if (m_read || m_write) begin
                if (!in_req) begin
                    in_req    = 1'b1;
                    st_cnt    = 0;
                    cur_stall = (stall_mode == 0) ? 0 :
                                (stall_mode == 1) ? int'($urandom_range(0, 3)) : fixed_stall;
                end
                m_wait = (st_cnt < cur_stall);
                st_cnt++;
                if (m_read) m_rdata = mem_rd(m_address);
                if (!m_wait) begin
                    in_req = 1'b0;
                    log_q.push_back('{m_write, m_address, m_write ? m_wd : m_rdata});
                    if (m_write) mem[m_address] = m_wd;
                end
            end else begin
                m_wait = 1'b0;
            end
            p_wait = m_wait;
            p_req  = m_read | m_write;
            p_rd   = m_read;
            p_wr   = m_write;
            p_addr = m_address;
            p_wd   = m_wd;
        end
    end

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        s_addr  = a;
        s_wd    = d;
        s_write = 1'b1;
        @(posedge clk);
        #1;
        s_write = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        s_addr = a;
        #1;
        d = s_rdata;
    endtask

    // Reference: each word is read from src+4i and then stored to dst+4i.
    task automatic model_copy(input bit [31:0] src, input bit [31:0] dst, input int len);
        bit [31:0] a;
        bit [31:0] b;
        bit [31:0] d;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            a = src + 32'(4 * i);
            b = dst + 32'(4 * i);
            d = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
            exp_q.push_back('{1'b0, a, d});
            ref_mem[b] = d;
            exp_q.push_back('{1'b1, b, d});
        end
    endtask

    task automatic cmp_log(input string tag);
        int n;
        check({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_kind"}, 32'(log_q[i].wr), 32'(exp_q[i].wr));
            check({tag, "_addr"}, log_q[i].addr, exp_q[i].addr);
            check({tag, "_data"}, log_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic wait_done(input int limit, output int cycles);
        s_addr = 2'd3;
        cycles = 0;
        #1;
        while (s_rdata[1] !== 1'b1 && cycles < limit) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("done_seen", 32'(s_rdata[1]), 32'd1);
    endtask

    // Programs and starts one copy, leaving the predicted traffic in exp_q.
    task automatic start_copy(input bit [31:0] src, input bit [31:0] dst, input int len,
                              input bit [31:0] ctrl);
        reg_wr(2'd0, src);
        reg_wr(2'd1, dst);
        reg_wr(2'd2, 32'(len));
        model_copy(src, dst, len);
        log_q.delete();
        reg_wr(2'd3, ctrl);
        check("read_after_start", 32'(m_read), 32'd1);
        check("addr_after_start", m_address, src);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          cyc;
        bit [31:0]   r_src;
        bit [31:0]   r_dst;
        int          r_len;
        bit          r_irq;

        reset   = 1'b1;
        s_addr  = 2'd0;
        s_read  = 1'b0;
        s_write = 1'b0;
        s_wd    = 32'd0;
        s_be    = 4'hF;
        m_wait  = 1'b0;
        m_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_read", 32'(m_read), 32'd0);
        check("rst_write", 32'(m_write), 32'd0);
        check("rst_addr", m_address, 32'd0);
        check("rst_wdata", m_wd, 32'd0);
        check("rst_be", 32'(m_be), 32'hF);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_swait", 32'(s_wait), 32'd0);
        for (int i = 0; i < 4; i++) begin
            reg_rd(2'(i), rd);
            check("rst_reg", rd, 32'd0);
        end

        // Register field handling
        reg_wr(2'd0, 32'h12345677);
        reg_rd(2'd0, rd);
        check("src_align", rd, 32'h12345674);
        reg_wr(2'd2, 32'hFFFFFF05);
        reg_rd(2'd2, rd);
        check("len_width", rd, 32'h00FFFF05);
        reg_wr(2'd3, 32'h8);
        reg_rd(2'd3, rd);
        check("fill_absent", rd, 32'd0);

        // Copy without stall
        stall_mode = 0;
        start_copy(32'h02000000, 32'h00001000, 4, 32'h1);
        wait_done(100, cyc);
        check("nostall_cycles", 32'(cyc), 32'd8);
        check("nostall_status", s_rdata, 32'h2);
        cmp_log("nostall");

        // Stall handling, three wait cycles on every request
        stall_mode  = 2;
        fixed_stall = 3;
        start_copy(32'h00002000, 32'h00003000, 2, 32'h1);
        wait_done(100, cyc);
        check("stall_cycles", 32'(cyc), 32'd16);
        cmp_log("stall");

        // Zero length: done immediately, no bus traffic
        stall_mode = 0;
        reg_wr(2'd2, 32'd0);
        log_q.delete();
        reg_wr(2'd3, 32'h1);
        s_addr = 2'd3;
        #1;
        check("zero_status", s_rdata, 32'h2);
        check("zero_noread", 32'(m_read), 32'd0);
        repeat (3) @(posedge clk);
        check("zero_traffic", 32'(log_q.size()), 32'd0);
        reg_wr(2'd3, 32'h2);
        reg_rd(2'd3, rd);
        check("clear_done", rd, 32'd0);

        // Busy protection: DST, LEN and start are ignored mid-copy
        stall_mode = 1;
        start_copy(32'h00004000, 32'h00005000, 8, 32'h1);
        reg_wr(2'd1, 32'h0000F000);
        reg_wr(2'd2, 32'd3);
        reg_wr(2'd3, 32'h1);
        wait_done(500, cyc);
        check("busy_status", s_rdata, 32'h2);
        cmp_log("busy");

        // Interrupt and address wrap
        stall_mode = 0;
        start_copy(32'hFFFFFFFC, 32'h00000300, 2, 32'h5);
        wait_done(100, cyc);
        check("wrap_irq", 32'(irq), 32'd1);
        cmp_log("wrap");
        reg_wr(2'd3, 32'h6);
        check("irq_cleared", 32'(irq), 32'd0);
        s_addr = 2'd3;
        #1;
        check("irq_en_kept", s_rdata, 32'h4);

        // Randomized copies
        stall_mode = 1;
        for (int k = 0; k < 6; k++) begin
            r_src = $urandom & 32'hFFFFFFFC;
            r_dst = $urandom & 32'hFFFFFFFC;
            r_len = int'($urandom_range(1, 6));
            r_irq = 1'($urandom_range(0, 1));
            start_copy(r_src, r_dst, r_len, {29'd0, r_irq, 2'b01});
            wait_done(300, cyc);
            check("rand_irq", 32'(irq), 32'(r_irq));
            cmp_log("rand");
        end

        // Reset in WR under waitrequest
        stall_mode  = 2;
        fixed_stall = 10;
        start_copy(32'h00006000, 32'h00007000, 2, 32'h5);
        cyc = 0;
        while (m_write !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_wr", 32'(m_write), 32'd1);
        stab_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("rst_drop_write", 32'(m_write), 32'd0);
        check("rst_drop_read", 32'(m_read), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            reg_rd(2'(i), rd);
            check("post_rst_reg", rd, 32'd0);
        end
        check("post_rst_irq", 32'(irq), 32'd0);
        check("post_rst_write", 32'(m_write), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
